// File: rtl/values_pkg.sv
// Shared definitions for the four-value symbol link: code constants,
// the receive FSM state type and the code-to-four-state decode helper.
package values_pkg;

  typedef logic [1:0] val_code_t;

  localparam val_code_t VAL_ZERO = 2'b00;
  localparam val_code_t VAL_ONE  = 2'b01;
  localparam val_code_t VAL_UNK  = 2'b10;
  localparam val_code_t VAL_IMP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    UNDER  = 2'd2
  } rx_state_t;

  // Map a 2-bit code onto the four-state logic value it stands for.
  function automatic logic decode_val(input val_code_t code);
    logic v;
    case (code)
      VAL_ZERO: v = 1'b0;
      VAL_ONE:  v = 1'b1;
      VAL_UNK:  v = 1'bx;
      default:  v = 1'bz;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/values_fifo.sv
// DEPTH x 2-bit synchronous FIFO with occupancy count; push is ignored
// when full and pop is ignored when empty.
module values_fifo
  import values_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  val_code_t                wdata,
  input  logic                     pop,
  output val_code_t                rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  val_code_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign level   = count_q;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/values_rx.sv
// Four-value symbol receiver: buffers 2-bit codes and replays them as a
// real four-state bit, one per enabled clock.
// Optional popped-symbol counters: define VALUES_RX_STATS_EN.
module values_rx
  import values_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [1:0]              s_code,
  input  logic                    o_en,
  output logic                    v_out,
  output logic                    v_valid,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  level,
`ifdef VALUES_RX_STATS_EN
  output logic [CNT_W-1:0]        cnt_zero,
  output logic [CNT_W-1:0]        cnt_one,
  output logic [CNT_W-1:0]        cnt_unk,
  output logic [CNT_W-1:0]        cnt_imp,
`endif
  input  logic                    stats_clr
);

  rx_state_t  state_q, state_d;
  logic       v_out_q, v_out_d;
  logic       underrun_q, underrun_d;
  val_code_t  head;
  logic       full;
  logic       empty;
  logic       pop_fire;

  values_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (val_code_t'(s_code)),
    .pop   (o_en),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign s_ready  = ~full;
  assign pop_fire = o_en & ~empty;
  assign v_out    = v_out_q;
  assign v_valid  = (state_q == STREAM);
  assign underrun = underrun_q;

  // Next state, reconstructed value and sticky underrun flag.
  always_comb begin
    state_d    = IDLE;
    v_out_d    = v_out_q;
    underrun_d = underrun_q;
    if (o_en) begin
      if (empty) begin
        state_d    = UNDER;
        v_out_d    = 1'bx;
        underrun_d = 1'b1;
      end else begin
        state_d    = STREAM;
        v_out_d    = decode_val(head);
      end
    end
    if (stats_clr) underrun_d = 1'b0;
  end

  // State and output registers; v_out idles at high impedance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v_out_q    <= 1'bz;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_out_q    <= v_out_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef VALUES_RX_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Saturating per-code pop counters; clear wins over increment.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (pop_fire && (head == val_code_t'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_zero = cnt_q[0];
  assign cnt_one  = cnt_q[1];
  assign cnt_unk  = cnt_q[2];
  assign cnt_imp  = cnt_q[3];
`endif

endmodule

// File: tb/tb_values_rx.sv
// Self-checking bench for values_rx: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_values_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_code;
  logic          o_en;
  logic          v_out;
  logic          v_valid;
  logic          underrun;
  logic [LW-1:0] level;
  logic          stats_clr;
`ifdef VALUES_RX_STATS_EN
  logic [CNT_W-1:0] cnt_zero, cnt_one, cnt_unk, cnt_imp;
`endif

  values_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_code    (s_code),
    .o_en      (o_en),
    .v_out     (v_out),
    .v_valid   (v_valid),
    .underrun  (underrun),
    .level     (level),
`ifdef VALUES_RX_STATS_EN
    .cnt_zero  (cnt_zero),
    .cnt_one   (cnt_one),
    .cnt_unk   (cnt_unk),
    .cnt_imp   (cnt_imp),
`endif
    .stats_clr (stats_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] m_q[$];
  logic       m_v;
  logic       m_valid;
  logic       m_under;
  int         m_cnt[4];

  int passed = 0;
  int total  = 0;

  function automatic logic code_to_val(input logic [1:0] c);
    case (c)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return 1'bx;
      default: return 1'bz;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_v(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_v = 1'bz;
    m_valid = 1'b0;
    m_under = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic check_all(input string tag);
    chk_v({tag, ".v_out"}, v_out, m_v);
    chk({tag, ".v_valid"}, 32'(v_valid), 32'(m_valid));
    chk({tag, ".underrun"}, 32'(underrun), 32'(m_under));
    chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(m_q.size() != DEPTH));
`ifdef VALUES_RX_STATS_EN
    chk({tag, ".cnt_zero"}, 32'(cnt_zero), 32'(m_cnt[0]));
    chk({tag, ".cnt_one"},  32'(cnt_one),  32'(m_cnt[1]));
    chk({tag, ".cnt_unk"},  32'(cnt_unk),  32'(m_cnt[2]));
    chk({tag, ".cnt_imp"},  32'(cnt_imp),  32'(m_cnt[3]));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic sv, input logic [1:0] code, input logic oe,
                      input logic clr, input string tag, input bit do_check);
    bit         rdy;
    bit         pop;
    logic [1:0] popped;
    s_valid = sv; s_code = code; o_en = oe; stats_clr = clr;
    rdy = (m_q.size() != DEPTH);
    pop = oe && (m_q.size() != 0);
    popped = pop ? m_q[0] : 2'b00;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(m_q.pop_front());
      m_v = code_to_val(popped);
    end else if (oe) begin
      m_v = 1'bx;
    end
    m_valid = pop;
    if (oe && !pop) m_under = 1'b1;
    if (clr) m_under = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (clr) m_cnt[i] = 0;
      else if (pop && popped == 2'(i) && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
    end
    if (sv && rdy) m_q.push_back(code);
    if (do_check) check_all(tag);
  endtask

  initial begin
    logic [1:0] seq [4];
    rst_n = 1'b0; s_valid = 1'b0; s_code = 2'b00; o_en = 1'b0; stats_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step(0, 0, 0, 0, "idle", 1);

    // Push 01,00,10,11 then stream them out
    seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b11;
    for (int i = 0; i < 4; i++) step(1, seq[i], 0, 0, "push4", 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "stream4", 1);

    // Overfill with o_en low, then one pop frees a slot
    for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 0, "fill", 1);
    chk("full.level", 32'(level), 32'(DEPTH));
    step(1, 2'b11, 1, 0, "full_pop", 1);
    step(1, 2'b11, 0, 0, "refill", 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "drain", 1);

    // Underrun, then push-with-pop on empty: no write-through
    step(0, 0, 1, 0, "under", 1);
    step(1, 2'b01, 1, 0, "under_push", 1);
    step(0, 0, 1, 0, "under_recover", 1);
    chk_v("recover.v_out", v_out, 1'b1);
    step(0, 0, 0, 1, "clr", 1);

    // Saturate the zero counter
    for (int i = 0; i < 300; i++) step(1, 2'b00, 1, 0, "sat", (i % 50) == 0);
    step(0, 0, 1, 0, "sat_end", 1);
    step(0, 0, 0, 0, "sat_idle", 1);
`ifdef VALUES_RX_STATS_EN
    chk("sat.cnt_zero", 32'(cnt_zero), 32'(255));
`endif

    // Random phase
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), "rand", 1);

    // Async reset mid-stream with three symbols buffered
    step(0, 0, 1, 0, "pre_rst_drain", 0);
    step(0, 0, 1, 0, "pre_rst_drain", 0);
    step(0, 0, 1, 0, "pre_rst_drain", 0);
    step(0, 0, 1, 0, "pre_rst_drain", 0);
    step(0, 0, 1, 0, "pre_rst_drain", 1);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 0, "pre_rst", 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 0, "post_rst", 1);
    step(0, 0, 0, 0, "post_rst_idle", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/values_rx.md
# values_rx

Receive-side counterpart of the four-value source block: accepts 2-bit encoded logic-value symbols (0, 1, unknown, high-impedance) over a valid/ready handshake, buffers them in a small FIFO, and drives them back out as a real four-state single-bit signal, one symbol per enabled clock. It sits at the sink end of the value-encoding link and lets testbenches and downstream logic observe 0/1/X/Z reconstructed from a synthesizable 2-bit code.

## Interface
- `DEPTH`, 4: FIFO depth in symbols; power of two, minimum 2.
- `CNT_W`, 8: width of each statistics counter.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input symbol valid.
- `s_ready` out 1: FIFO can accept a symbol.
- `s_code` in 2: symbol code. 00 = 0, 01 = 1, 10 = X (unknown), 11 = Z (impedance).
- `o_en` in 1: consumer requests one symbol this cycle.
- `v_out` out 1: reconstructed four-state value.
- `v_valid` out 1: `v_out` was loaded from a popped symbol at the last edge.
- `underrun` out 1: sticky; set when `o_en` is high while the FIFO is empty.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `cnt_zero`, `cnt_one`, `cnt_unk`, `cnt_imp` out CNT_W each: popped-symbol counts. Present only with `VALUES_RX_STATS_EN`.
- `stats_clr` in 1: synchronous clear of the counters and `underrun`.

## Operation
- Push happens when `s_valid & s_ready`. `s_ready = (level != DEPTH)` and is derived from registered state only.
- Pop happens when `o_en & (level != 0)`. The head code is decoded into `v_out_q`: 00→1'b0, 01→1'b1, 10→1'bx, 11→1'bz.
- FSM states:
  - IDLE: `o_en` low, `v_out` holds its value.
  - STREAM: last edge popped a symbol.
  - UNDER: `o_en` high with the FIFO empty. `v_out` is driven to 1'bx and `underrun` is set.
- FSM transitions, evaluated every edge:
  - `o_en` = 0 → IDLE.
  - `o_en` = 1 and FIFO not empty → STREAM.
  - `o_en` = 1 and FIFO empty → UNDER.
  - UNDER → STREAM on the first edge where `o_en` = 1 and the FIFO is not empty.
- `v_valid` is high exactly in STREAM.
- Simultaneous push and pop with 0 < level < DEPTH: `level` is unchanged and both pointers advance.
- FIFO full: `s_ready` is low, so no push occurs even if a pop happens in the same cycle. `s_ready` rises on the following cycle.
- FIFO empty with a push and `o_en` in the same cycle: there is no write-through. The state goes to UNDER for that cycle, and the symbol pops on the next edge.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Counters increment on pop according to the popped code and saturate at 2^CNT_W−1.
- `stats_clr` has priority over an increment in the same cycle and clears `underrun`. It does not affect the FIFO.

## Timing
- Reset values: `v_out` = 1'bz, `v_valid` = 0, `underrun` = 0, `level` = 0, `s_ready` = 1, all counters 0, state IDLE, pointers 0.
- Reset is asynchronous. Asserting it mid-stream discards FIFO contents immediately.
- Latency: a symbol accepted at edge t can be popped at edge t+1 at the earliest. `v_out` shows it after edge t+1.
- Throughput is one symbol per cycle in each direction.
- Occupancy:
  - `level` updates on the same edge as the push or pop.
  - `s_ready` falls in the cycle after the push that fills the FIFO.

## Configuration
- `VALUES_RX_STATS_EN`:
  - Defined: the four counters and their ports exist, with saturating counts cleared by `stats_clr`.
  - Undefined: the counters and their ports are removed. `stats_clr` still clears `underrun`.
- FIFO, FSM and decode behaviour are identical in both builds.

## Structure
- Shared package `values_pkg` holds:
  - Code constants `VAL_ZERO=2'b00`, `VAL_ONE=2'b01`, `VAL_UNK=2'b10`, `VAL_IMP=2'b11`.
  - Typedef `val_code_t` (2 bits).
  - FSM enum `rx_state_t` {IDLE, STREAM, UNDER}.
- One sub-module, `values_fifo`: parameterized DEPTH×2-bit synchronous FIFO providing push/pop/level/full/empty.
- Decoder, FSM and counters live in the top module.

## Test plan
- Reset, then no stimulus → `v_out` === 1'bz, `level` = 0, `s_ready` = 1, `underrun` = 0.
- Push codes 01, 00, 10, 11, then hold `o_en` = 1 for 4 cycles → `v_out` is 1, 0, x, z on successive cycles, `v_valid` = 1 each cycle, each counter = 1.
- With `o_en` low, push 5 symbols with DEPTH = 4 → only 4 are accepted, `s_ready` = 0, `level` = 4. A single pop raises `s_ready` the next cycle and the 5th symbol is accepted.
- `o_en` = 1 with the FIFO empty → state UNDER, `v_out` === 1'bx, `underrun` = 1 (sticky). Pushing 01 gives `v_out` = 1 two edges later. `stats_clr` clears `underrun`.
- Stream 300 pops of code 00 with CNT_W = 8 → `cnt_zero` saturates at 255 and the other counters stay 0.
- Assert `rst_n` low mid-stream with `level` = 3 → outputs return to reset values asynchronously and no stale symbol appears after release.
